// File: rtl/router_pkg.sv
// Shared flit field map and encodings for the deflection router datapath.
package router_pkg;

    // Flit field positions (32-bit flit)
    localparam int GOLD_B    = 0;
    localparam int EJ_B      = 1;
    localparam int IPORT_LSB = 2;
    localparam int OPORT_LSB = 4;
    localparam int SRC_LSB   = 7;
    localparam int DST_LSB   = 11;
    localparam int SEQ_LSB   = 15;
    localparam int SEQ_W     = 5;
    localparam int OPORT_W   = 3;

    localparam logic [OPORT_W-1:0] OPORT_LOCAL = 3'b100;
    localparam int                 NPORTS      = 4;

    typedef enum logic [1:0] {
        PORT_N = 2'd0,
        PORT_E = 2'd1,
        PORT_S = 2'd2,
        PORT_W = 2'd3
    } port_e;

    // Occupancy classes of the ejection FIFO
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_NORMAL  = 2'd1,
        OCC_RESERVE = 2'd2,
        OCC_FULL    = 2'd3
    } occ_state_e;

    typedef logic [SEQ_W:0] prio_key_t;

    // Larger key = higher priority: golden first, then the smaller sequence number.
    function automatic prio_key_t prio_key(input logic golden, input logic [SEQ_W-1:0] seq);
        return {golden, ~seq};
    endfunction

endpackage

// File: rtl/eject_sched_ctrl_if.sv
// Ejection port towards the local PE: valid/ready handshake carrying one flit.
interface eject_sched_ctrl_if #(
    parameter int FLIT_W = 32
);
    logic [FLIT_W-1:0] ej_flit;
    logic              ej_valid;
    logic              ej_ready;

    modport master (
        output ej_flit,
        output ej_valid,
        input  ej_ready
    );

    modport slave (
        input  ej_flit,
        input  ej_valid,
        output ej_ready
    );
endinterface

// File: rtl/eject_sched_ctrl_fifo.sv
// Small circular ejection FIFO; push/pop are ignored when full/empty respectively.
module eject_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] cnt
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign cnt     = cnt_q;

    // Next pointer/count; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; entries are only observable once written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/eject_sched_ctrl.sv
// Ejection scheduler: picks at most one local-bound flit per cycle into the
// ejection FIFO, registers everything else through to the deflection stage.
module eject_sched_ctrl
    import router_pkg::*;
#(
    parameter int FLIT_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int RESV_SLOTS = 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [FLIT_W-1:0]   in_0,
    input  logic [FLIT_W-1:0]   in_1,
    input  logic [FLIT_W-1:0]   in_2,
    input  logic [FLIT_W-1:0]   in_3,
    input  logic [NPORTS-1:0]   in_vld,
    output logic [FLIT_W-1:0]   out_0,
    output logic [FLIT_W-1:0]   out_1,
    output logic [FLIT_W-1:0]   out_2,
    output logic [FLIT_W-1:0]   out_3,
    output logic [NPORTS-1:0]   out_vld,
    eject_sched_ctrl_if.master  ej,
    output logic                throttle,
    output logic [CNT_W-1:0]    fifo_cnt
);

    localparam logic [CNT_W-1:0] RESV_TH = CNT_W'(FIFO_DEPTH - RESV_SLOTS);
    localparam logic [CNT_W-1:0] FULL_TH = CNT_W'(FIFO_DEPTH);
    localparam int               MKEY_W  = SEQ_W + 2;  // {eligible, golden, ~seq}

    logic [FLIT_W-1:0] in_flit [NPORTS];
    logic [FLIT_W-1:0] out_q   [NPORTS];
    logic [FLIT_W-1:0] out_d   [NPORTS];
    logic [NPORTS-1:0] out_vld_q, out_vld_d;

    logic [NPORTS-1:0] req, elig, tie_mask, win_vec;
    logic [MKEY_W-1:0] mkey [NPORTS];
    logic [MKEY_W-1:0] best_lo, best_hi, best;
    logic              win_any, multi_tie;
    logic [1:0]        win_idx;
    logic [1:0]        rr_q, rr_d;
    logic [FLIT_W-1:0] win_flit;

    logic              push, pop;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  cnt_w, cnt_nx;
    logic [FLIT_W-1:0] fifo_head;

    occ_state_e        occ_q, occ_d;
    logic              throttle_q, throttle_d;

    assign in_flit[0] = in_0;
    assign in_flit[1] = in_1;
    assign in_flit[2] = in_2;
    assign in_flit[3] = in_3;

    function automatic logic [MKEY_W-1:0] kmax(input logic [MKEY_W-1:0] a, input logic [MKEY_W-1:0] b);
        return (a >= b) ? a : b;
    endfunction

    function automatic occ_state_e occ_of(input logic [CNT_W-1:0] c);
        if (c == '0)          return OCC_EMPTY;
        else if (c >= FULL_TH) return OCC_FULL;
        else if (c >= RESV_TH) return OCC_RESERVE;
        else                   return OCC_NORMAL;
    endfunction

    // Local requests, filtered by the occupancy seen at the start of the cycle.
    always_comb begin
        req  = '0;
        elig = '0;
        for (int i = 0; i < NPORTS; i++) begin
            req[i] = in_vld[i] && (in_flit[i][OPORT_LSB +: OPORT_W] == OPORT_LOCAL);
        end
        case (occ_q)
            OCC_FULL:    elig = '0;
            OCC_RESERVE: for (int i = 0; i < NPORTS; i++) elig[i] = req[i] && in_flit[i][GOLD_B];
            default:     elig = req;
        endcase
        if (fifo_full) elig = '0;
    end

    // Compare tree: ineligible ports carry a zero top bit so they never win.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            mkey[i] = {elig[i], prio_key(in_flit[i][GOLD_B], in_flit[i][SEQ_LSB +: SEQ_W])};
        end
        best_lo = kmax(mkey[0], mkey[1]);
        best_hi = kmax(mkey[2], mkey[3]);
        best    = kmax(best_lo, best_hi);
        win_any = best[MKEY_W-1];
        for (int i = 0; i < NPORTS; i++) begin
            tie_mask[i] = elig[i] && (mkey[i] == best);
        end
        multi_tie = ($countones(tie_mask) > 1);
    end

    // Round-robin resolution among equally ranked candidates, starting at rr_q.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        found   = 1'b0;
        idx     = '0;
        win_idx = rr_q;
        for (int k = 0; k < NPORTS; k++) begin
            idx = rr_q + 2'(k);
            if (!found && tie_mask[idx]) begin
                win_idx = idx;
                found   = 1'b1;
            end
        end
        win_vec         = win_any ? (NPORTS'(1) << win_idx) : '0;
        rr_d            = (win_any && multi_tie) ? (win_idx + 2'd1) : rr_q;
        win_flit        = in_flit[win_idx];
        win_flit[EJ_B]  = 1'b1;
    end

    assign push = win_any;
    assign pop  = !fifo_empty && ej.ej_ready;

    eject_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FLIT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (win_flit),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .cnt       (cnt_w)
    );

    // Occupancy after this edge drives the state class and the throttle flag.
    always_comb begin
        cnt_nx = cnt_w;
        case ({push, pop})
            2'b10:   cnt_nx = cnt_w + CNT_W'(1);
            2'b01:   cnt_nx = cnt_w - CNT_W'(1);
            default: cnt_nx = cnt_w;
        endcase
        occ_d      = occ_of(cnt_nx);
        throttle_d = (cnt_nx >= RESV_TH);
    end

    // Occupancy state machine with registered throttle and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= OCC_EMPTY;
            throttle_q <= 1'b0;
            rr_q       <= '0;
        end else begin
            occ_q      <= occ_d;
            throttle_q <= throttle_d;
            rr_q       <= rr_d;
        end
    end

    // Pass-through data: ejected flag is always cleared on deflected flits.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            out_d[i]       = in_flit[i];
            out_d[i][EJ_B] = 1'b0;
        end
        out_vld_d = in_vld & ~win_vec;
    end

    // Pass-through register stage towards the deflection network.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPORTS; i++) out_q[i] <= '0;
            out_vld_q <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) out_q[i] <= out_d[i];
            out_vld_q <= out_vld_d;
        end
    end

    assign out_0       = out_q[0];
    assign out_1       = out_q[1];
    assign out_2       = out_q[2];
    assign out_3       = out_q[3];
    assign out_vld     = out_vld_q;
    assign throttle    = throttle_q;
    assign fifo_cnt    = cnt_w;
    assign ej.ej_flit  = fifo_head;
    assign ej.ej_valid = !fifo_empty;

endmodule

// File: tb/tb_eject_sched_ctrl.sv
// Self-checking bench for eject_sched_ctrl: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_eject_sched_ctrl;

    localparam int DEPTH = 4;
    localparam int RESV  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_0, in_1, in_2, in_3;
    logic [3:0]  in_vld;
    logic [31:0] out_0, out_1, out_2, out_3;
    logic [3:0]  out_vld;
    logic        throttle;
    logic [2:0]  fifo_cnt;

    eject_sched_ctrl_if #(.FLIT_W(32)) ej_if ();

    eject_sched_ctrl #(
        .FLIT_W     (32),
        .FIFO_DEPTH (DEPTH),
        .RESV_SLOTS (RESV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_0     (in_0),
        .in_1     (in_1),
        .in_2     (in_2),
        .in_3     (in_3),
        .in_vld   (in_vld),
        .out_0    (out_0),
        .out_1    (out_1),
        .out_2    (out_2),
        .out_3    (out_3),
        .out_vld  (out_vld),
        .ej       (ej_if),
        .throttle (throttle),
        .fifo_cnt (fifo_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] mq[$];
    int          rr_m = 0;
    logic [31:0] exp_out [4];
    logic [3:0]  exp_vld;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit beats(input logic [31:0] a, input logic [31:0] b);
        if (a[0] != b[0]) return a[0];
        return a[19:15] < b[19:15];
    endfunction

    task automatic check_outputs();
        chk("out_vld", out_vld, exp_vld);
        chk("out_0", out_0, exp_out[0]);
        chk("out_1", out_1, exp_out[1]);
        chk("out_2", out_2, exp_out[2]);
        chk("out_3", out_3, exp_out[3]);
        chk("ej_valid", ej_if.ej_valid, mq.size() > 0);
        if (mq.size() > 0) chk("ej_flit", ej_if.ej_flit, mq[0]);
        chk("throttle", throttle, mq.size() >= DEPTH - RESV);
        chk("fifo_cnt", fifo_cnt, mq.size());
    endtask

    // Drive one cycle of inputs, advance the model, and compare after the edge.
    task automatic step(input logic [31:0] f0, input logic [31:0] f1,
                        input logic [31:0] f2, input logic [31:0] f3,
                        input logic [3:0] v, input logic rdy);
        logic [31:0] f [4];
        bit          el [4];
        int          w;
        int          nt;
        int          c;
        f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
        in_0 = f0; in_1 = f1; in_2 = f2; in_3 = f3;
        in_vld = v;
        ej_if.ej_ready = rdy;
        c  = mq.size();
        w  = -1;
        nt = 0;
        for (int p = 0; p < 4; p++) begin
            el[p] = v[p] && (f[p][6:4] == 3'b100) && (c < DEPTH) && (f[p][0] || (c < DEPTH - RESV));
        end
        for (int k = 0; k < 4; k++) begin
            int p;
            p = (rr_m + k) % 4;
            if (el[p] && (w < 0 || beats(f[p], f[w]))) w = p;
        end
        if (w >= 0) begin
            for (int p = 0; p < 4; p++) begin
                if (el[p] && f[p][0] == f[w][0] && f[p][19:15] == f[w][19:15]) nt++;
            end
            if (nt > 1) rr_m = (w + 1) % 4;
        end
        if (c > 0 && rdy) void'(mq.pop_front());
        if (w >= 0) mq.push_back(f[w] | 32'h2);
        for (int p = 0; p < 4; p++) begin
            exp_out[p] = f[p] & ~32'h2;
            exp_vld[p] = v[p] && (p != w);
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ej_valid", ej_if.ej_valid, 1'b0);
        chk("rst_out_vld", out_vld, 4'b0000);
        chk("rst_throttle", throttle, 1'b0);
        chk("rst_fifo_cnt", fifo_cnt, 3'd0);
        chk("rst_out_0", out_0, 32'h0);
        mq.delete();
        rr_m = 0;
        for (int p = 0; p < 4; p++) exp_out[p] = '0;
        exp_vld = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rflit();
        logic [31:0] f;
        f = $urandom();
        if ($urandom_range(0, 1) == 1) f[6:4] = 3'b100;
        f[0]     = ($urandom_range(0, 3) == 0);
        f[19:15] = 5'($urandom_range(0, 3));
        return f;
    endfunction

    initial begin
        in_0 = '0; in_1 = '0; in_2 = '0; in_3 = '0;
        in_vld = '0;
        ej_if.ej_ready = 1'b0;

        // Reset state
        #12;
        chk("init_ej_valid", ej_if.ej_valid, 1'b0);
        chk("init_out_vld", out_vld, 4'b0000);
        chk("init_throttle", throttle, 1'b0);
        chk("init_fifo_cnt", fifo_cnt, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int p = 0; p < 4; p++) exp_out[p] = '0;
        exp_vld = '0;

        // Single local flit
        step(32'h00018040, 0, 0, 0, 4'b0001, 1'b0);
        chk("t1_ej_flit", ej_if.ej_flit, 32'h00018042);
        chk("t1_ej_valid", ej_if.ej_valid, 1'b1);
        chk("t1_out_vld0", out_vld[0], 1'b0);
        chk("t1_cnt", fifo_cnt, 3'd1);
        step(0, 0, 0, 0, 4'b0000, 1'b1);

        // Golden beats lower sequence number
        step(0, 32'h00028041, 32'h00008040, 0, 4'b0110, 1'b0);
        chk("t2_out_2", out_2, 32'h00008040);
        chk("t2_out_vld2", out_vld[2], 1'b1);
        chk("t2_out_vld1", out_vld[1], 1'b0);
        chk("t2_ej_flit", ej_if.ej_flit, 32'h00028043);

        // Equal-key tie resolved by round robin
        async_reset();
        step(32'h00018040, 0, 0, 32'h00018040, 4'b1001, 1'b1);
        chk("t3_first_win0", out_vld, 4'b1000);
        step(32'h00018040, 0, 0, 32'h00018040, 4'b1001, 1'b1);
        chk("t3_second_win3", out_vld, 4'b0001);

        // Throttling with the reserved golden slot
        async_reset();
        repeat (3) step(32'h00018040, 0, 0, 0, 4'b0001, 1'b0);
        chk("t4_cnt3", fifo_cnt, 3'd3);
        chk("t4_throttle", throttle, 1'b1);
        step(32'h00018040, 0, 0, 0, 4'b0001, 1'b0);
        chk("t4_ng_passes", out_vld[0], 1'b1);
        step(0, 32'h00028041, 0, 0, 4'b0010, 1'b0);
        chk("t4_golden_in", fifo_cnt, 3'd4);
        chk("t4_golden_out_vld", out_vld[1], 1'b0);
        step(0, 32'h00028041, 0, 0, 4'b0010, 1'b0);
        chk("t4_full_deflect", out_vld[1], 1'b1);
        chk("t4_full_cnt", fifo_cnt, 3'd4);

        // Simultaneous push and pop
        async_reset();
        repeat (2) step(32'h00018040, 0, 0, 0, 4'b0001, 1'b0);
        step(32'h00028040, 0, 0, 0, 4'b0001, 1'b1);
        chk("t5_cnt_hold", fifo_cnt, 3'd2);

        // FIFO ordering across pointer wrap
        async_reset();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] f;
            f = 32'h00000040;
            f[19:15] = 5'(i);
            step(f, 0, 0, 0, 4'b0001, 1'b1);
            chk("t6_order", ej_if.ej_flit[19:15], 5'(i));
        end
        step(0, 0, 0, 0, 4'b0000, 1'b1);
        chk("t6_drained", ej_if.ej_valid, 1'b0);

        // Reset mid-operation with three entries buffered
        repeat (3) step(32'h00018040, 0, 0, 0, 4'b0001, 1'b0);
        chk("t7_cnt3", fifo_cnt, 3'd3);
        async_reset();
        step(0, 0, 32'h00010040, 0, 4'b0100, 1'b0);
        chk("t7_head_after_rst", ej_if.ej_flit, 32'h00010042);
        chk("t7_cnt_after_rst", fifo_cnt, 3'd1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            step(rflit(), rflit(), rflit(), rflit(), 4'($urandom()),
                 ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
